agc_sequencer: RTL and testbench
================================

Name: agc_sequencer

Overview:
- Hardware automatic-gain-control loop for the three RF channels.
- Measures each channel's 2-bit quantizer output over a fixed sample window, round-robin ch1→ch2→ch3.
- Compares the outer-level occupancy to a CPU-set target band and steps that channel's 10-bit PWM gain word up or down.
- Sits between the quantizers and the pwm instances; the housekeeping CPU supplies target, step, settle time and initial gains through out-ports.

Parameters:
- WINDOW_LOG2, 12, log2 of qualifying samples per measurement window; legal range 8..16.

Ports:
- clk  in  1  sample clock (clk64 domain)
- reset  in  1  asynchronous, active-high
- enable  in  1  run loop; low forces IDLE
- sample_en  in  1  sample qualifier; only cycles with sample_en=1 are counted
- ch1_s  in  2  ch1 quantized sample; bit1 = sign, bit0 = outer-level (magnitude) flag
- ch2_s  in  2  ch2 quantized sample, same encoding
- ch3_s  in  2  ch3 quantized sample, same encoding
- target_lo  in  8  lower bound of the acceptable occupancy level
- target_hi  in  8  upper bound of the acceptable occupancy level
- step  in  4  gain increment/decrement per update
- settle  in  16  cycles to wait before counting, allowing the PWM filter to settle
- init_gain  in  10  value written by load
- load  in  3  one-hot per channel (bit0 = ch1); loads init_gain into that channel's gain register
- gain_ch1  out  10  PWM word, ch1
- gain_ch2  out  10  PWM word, ch2
- gain_ch3  out  10  PWM word, ch3
- ch_sel  out  2  channel under measurement (0..2)
- last_level  out  8  level computed at the most recent update
- update  out  1  one-cycle strobe when a gain decision is made
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): gain_ch1/2/3 = 512; ch_sel = 0; last_level = 0; update = 0; busy = 0; state IDLE; all counters 0.
- All outputs are registered.
- Gain sense: a larger gain word gives a larger signal.
- State machine:
  - IDLE: if enable, go to SETTLE with ch_sel = 0 and settle counter = 0.
  - SETTLE: count clk cycles (not gated by sample_en). When counter == settle, go to COUNT. settle = 0 means exactly one cycle in SETTLE.
  - COUNT: on each cycle with sample_en = 1, increment the sample counter; also increment the hit counter if the selected channel's bit0 = 1. When the sample counter reaches 2^WINDOW_LOG2 (that last sample included), go to UPDATE. Gaps in sample_en extend the window.
  - UPDATE (1 cycle): compute level = min(255, hits >> (WINDOW_LOG2-8)). Hit counter is WINDOW_LOG2+1 bits wide.
    - level > target_hi: gain = max(0, gain − step).
    - level < target_lo: gain = min(1023, gain + step).
    - Otherwise, or if target_lo > target_hi: gain unchanged.
    - Arithmetic is 11-bit with clamp; no wrap-around.
    - The new gain, last_level and update = 1 all appear on the same edge.
    - Next state: SETTLE with ch_sel advanced (2 wraps to 0). Counters are cleared.
- enable low in any state: next edge goes to IDLE. Counters are cleared, no update is issued, gains are held, and ch_sel resets to 0. Re-enable always restarts at ch1 with SETTLE.
- load: takes effect on the next edge in any state, including IDLE.
  - If load targets the channel being updated in the same cycle, the load value wins and update still pulses.
  - Multiple load bits may be set; all targeted channels are loaded.
- Inputs target_lo/target_hi/step/settle are sampled live; changing them mid-window affects only the comparisons made afterward.
- update is never high for two consecutive cycles.

Test Plan:
- Reset asserted mid-COUNT → all gains 512 immediately, busy = 0, update = 0, last_level = 0; after release with enable = 1, busy rises on the first edge.
- WINDOW_LOG2 = 8, settle = 4, step = 8, lo = 64, hi = 96, sample_en = 1, ch1_s bit0 = 1 always → update pulses with ch_sel = 0, last_level = 255, gain_ch1 = 504. Occurs 5 settle + 256 count cycles after entering SETTLE.
- Same config, ch2 bit0 = 0 always → last_level = 0, gain_ch2 = 520. Then load ch3 with 1020 and hold ch3 bit0 = 0 → gain_ch3 = 1023 (clamped). Load 3 → with level 255, gain_ch3 = 0.
- ch1 pattern with 80 hits in 256 samples → last_level = 80, gain_ch1 unchanged, update still pulses. Set lo = 100, hi = 50 → no change regardless of level.
- sample_en toggling every other cycle → window takes 512 cycles; hit count is identical to the continuous case.
- enable dropped at COUNT sample 100 → busy = 0 next cycle, no update, gains held. Re-enable → ch_sel = 0, full settle + window before the next update. load[0] coincident with a ch1 UPDATE → gain_ch1 = init_gain.

Source files
------------

// File: rtl/agc_sequencer.sv
// Round-robin AGC loop: measures outer-level occupancy of three quantized RF
// channels over a sample window and steps each channel's 10-bit PWM gain word.
module agc_sequencer #(
    parameter int WINDOW_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_en,
    input  logic [1:0]  ch1_s,
    input  logic [1:0]  ch2_s,
    input  logic [1:0]  ch3_s,
    input  logic [7:0]  target_lo,
    input  logic [7:0]  target_hi,
    input  logic [3:0]  step,
    input  logic [15:0] settle,
    input  logic [9:0]  init_gain,
    input  logic [2:0]  load,
    output logic [9:0]  gain_ch1,
    output logic [9:0]  gain_ch2,
    output logic [9:0]  gain_ch3,
    output logic [1:0]  ch_sel,
    output logic [7:0]  last_level,
    output logic        update,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        COUNT,
        UPDATE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [15:0]            settle_cnt_q;
    logic [WINDOW_LOG2-1:0] sample_cnt_q;
    logic [WINDOW_LOG2:0]   hit_cnt_q;
    logic [WINDOW_LOG2:0]   hit_cnt_inc;
    logic [WINDOW_LOG2:0]   level_shift;
    logic [9:0]             gain_q [3];

    logic                   sel_flag;
    logic                   window_done;
    logic [7:0]             level;
    logic [9:0]             gain_cur;
    logic [10:0]            gain_up;
    logic [10:0]            gain_dn;
    logic [9:0]             gain_new;
    logic                   band_ok;

    // The sign bits carry no occupancy information; only the magnitude flag is measured.
    logic unused_sign_bits;
    assign unused_sign_bits = ch1_s[1] ^ ch2_s[1] ^ ch3_s[1];

    assign gain_ch1 = gain_q[0];
    assign gain_ch2 = gain_q[1];
    assign gain_ch3 = gain_q[2];

    // Channel mux for the magnitude flag and the gain word under measurement.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_flag = ch1_s[0];
        gain_cur = gain_q[0];
        case (ch_sel)
            2'd1: begin
                sel_flag = ch2_s[0];
                gain_cur = gain_q[1];
            end
            2'd2: begin
                sel_flag = ch3_s[0];
                gain_cur = gain_q[2];
            end
            default: begin
                sel_flag = ch1_s[0];
                gain_cur = gain_q[0];
            end
        endcase
    end

    assign hit_cnt_inc = hit_cnt_q + {{WINDOW_LOG2{1'b0}}, sel_flag};
    assign window_done = sample_en && (sample_cnt_q == '1);

    // The decision is taken on the edge that counts the last sample, so the
    // level is derived from the hit count including that sample.
    assign level_shift = hit_cnt_inc >> (WINDOW_LOG2 - 8);
    assign level       = (|level_shift[WINDOW_LOG2:8]) ? 8'hFF : level_shift[7:0];

    assign gain_up = {1'b0, gain_cur} + {7'd0, step};
    assign gain_dn = {1'b0, gain_cur} - {7'd0, step};
    assign band_ok = (target_lo <= target_hi);

    always_comb begin
        gain_new = gain_cur;
        if (band_ok) begin
            if (level > target_hi) begin
                gain_new = gain_dn[10] ? 10'd0 : gain_dn[9:0];
            end else if (level < target_lo) begin
                gain_new = gain_up[10] ? 10'h3FF : gain_up[9:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = SETTLE;
            SETTLE:  if (settle_cnt_q == settle) state_d = COUNT;
            COUNT:   if (window_done) state_d = UPDATE;
            UPDATE:  state_d = SETTLE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            hit_cnt_q    <= '0;
            ch_sel       <= 2'd0;
            last_level   <= 8'd0;
            update       <= 1'b0;
            busy         <= 1'b0;
            // NOTE: the gain words are three plain flops, not a RAM, so resetting
            // the whole array is cheap and gives a defined power-up gain.
            for (int i = 0; i < 3; i++) begin
                gain_q[i] <= 10'd512;
            end
        end else begin
            update <= 1'b0;
            busy   <= (state_d != IDLE);

            if (state_d == IDLE) begin
                settle_cnt_q <= '0;
                sample_cnt_q <= '0;
                hit_cnt_q    <= '0;
                ch_sel       <= 2'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        settle_cnt_q <= '0;
                        sample_cnt_q <= '0;
                        hit_cnt_q    <= '0;
                        ch_sel       <= 2'd0;
                    end
                    SETTLE: begin
                        settle_cnt_q <= (state_d == COUNT) ? 16'd0 : settle_cnt_q + 16'd1;
                    end
                    COUNT: begin
                        if (state_d == UPDATE) begin
                            sample_cnt_q <= '0;
                            hit_cnt_q    <= '0;
                            update       <= 1'b1;
                            last_level   <= level;
                            for (int i = 0; i < 3; i++) begin
                                if (ch_sel == 2'(i)) gain_q[i] <= gain_new;
                            end
                        end else if (sample_en) begin
                            sample_cnt_q <= sample_cnt_q + 1'b1;
                            hit_cnt_q    <= hit_cnt_inc;
                        end
                    end
                    UPDATE: begin
                        settle_cnt_q <= '0;
                        ch_sel       <= (ch_sel == 2'd2) ? 2'd0 : ch_sel + 2'd1;
                    end
                    default: begin
                        settle_cnt_q <= '0;
                    end
                endcase
            end

            // A CPU load overrides any gain decision made on the same edge.
            for (int i = 0; i < 3; i++) begin
                if (load[i]) gain_q[i] <= init_gain;
            end
        end
    end

endmodule

// File: tb/tb_agc_sequencer.sv
// Scoreboard bench for agc_sequencer: stimulus pushes hand-computed update
// results, a negedge monitor pops and compares each update strobe.
module tb_agc_sequencer;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_en;
    logic [1:0]  ch1_s, ch2_s, ch3_s;
    logic [7:0]  target_lo, target_hi;
    logic [3:0]  step;
    logic [15:0] settle;
    logic [9:0]  init_gain;
    logic [2:0]  load;
    logic [9:0]  gain_ch1, gain_ch2, gain_ch3;
    logic [1:0]  ch_sel;
    logic [7:0]  last_level;
    logic        update, busy;

    always #5 clk = ~clk;

    agc_sequencer #(.WINDOW_LOG2(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample_en(sample_en),
        .ch1_s(ch1_s), .ch2_s(ch2_s), .ch3_s(ch3_s),
        .target_lo(target_lo), .target_hi(target_hi), .step(step),
        .settle(settle), .init_gain(init_gain), .load(load),
        .gain_ch1(gain_ch1), .gain_ch2(gain_ch2), .gain_ch3(gain_ch3),
        .ch_sel(ch_sel), .last_level(last_level), .update(update), .busy(busy)
    );

    typedef struct {
        int ch;
        int level;
        int g1;
        int g2;
        int g3;
        int cmin;
        int cmax;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pop   = 0;
    int   cyc     = 0;
    int   last_upd_cyc = 0;
    logic prev_update = 1'b0;

    // Channel pattern modes: 0 = flag low, 1 = flag high, 2 = 5 of every 16 samples.
    int   ch_mode [3] = '{0, 0, 0};
    int   se_mode = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push(input int ch, input int lvl, input int g1, input int g2, input int g3,
                        input int cmin, input int cmax);
        exp_t x;
        x.ch = ch; x.level = lvl; x.g1 = g1; x.g2 = g2; x.g3 = g3;
        x.cmin = cmin; x.cmax = cmax;
        sb.push_back(x);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n = 0;
        while (n_pop < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_tests++;
        if (n_pop < target) begin
            n_fail++;
            $display("FAIL update_timeout: got %0d updates expected %0d", n_pop, target);
        end
        #1;
    endtask

    task automatic start_run(output int k);
        @(posedge clk);
        #1;
        enable = 1'b1;
        k = cyc;
    endtask

    task automatic stop_run(input string name);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_busy"}, busy, 0);
        check({name, "_ch_sel"}, ch_sel, 0);
        check({name, "_update"}, update, 0);
        @(posedge clk);
        #1;
    endtask

    // Input driver: sample qualifier and per-sample channel patterns.
    initial begin
        int   sidx;
        logic tog;
        logic b [3];
        sidx = 0;
        tog  = 1'b1;
        sample_en = 1'b1;
        ch1_s = 2'b00; ch2_s = 2'b00; ch3_s = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            sample_en = (se_mode == 0) ? 1'b1 : tog;
            for (int c = 0; c < 3; c++) begin
                b[c] = (ch_mode[c] == 1) || (ch_mode[c] == 2 && (sidx % 16) < 5);
            end
            ch1_s = {sidx[0], b[0]};
            ch2_s = {~sidx[0], b[1]};
            ch3_s = {sidx[1], b[2]};
            if (sample_en) sidx++;
        end
    end

    // Monitor: every update strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && update) begin
            check("update_gap", prev_update, 0);
            check("update_busy", busy, 1);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: ch_sel=%0d level=%0d expected no update", ch_sel, last_level);
            end else begin
                e = sb.pop_front();
                check("upd_ch_sel", ch_sel, e.ch);
                check("upd_level", last_level, e.level);
                check("upd_gain_ch1", gain_ch1, e.g1);
                check("upd_gain_ch2", gain_ch2, e.g2);
                check("upd_gain_ch3", gain_ch3, e.g3);
                check_range("upd_cycle", cyc, e.cmin, e.cmax);
            end
            last_upd_cyc = cyc;
            n_pop++;
        end
        prev_update = update;
    end

    initial begin
        int k;
        int c10;
        reset = 1'b1; enable = 1'b0; load = 3'b000; init_gain = 10'd0;
        target_lo = 8'd64; target_hi = 8'd96; step = 4'd8; settle = 16'd4;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gain_ch1", gain_ch1, 512);
        check("rst_gain_ch2", gain_ch2, 512);
        check("rst_gain_ch3", gain_ch3, 512);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_level", last_level, 0);
        check("rst_update", update, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Saturating steps in both directions, plus clamp at 1023 and 0 after loads.
        ch_mode = '{1, 0, 0};
        start_run(k);
        push(0, 255, 504, 512, 512, k + 262, k + 262);
        push(1, 0, 504, 520, 512, k + 524, k + 524);
        wait_pops(2, 2000);
        load = 3'b100; init_gain = 10'd1020;
        @(posedge clk); #1 load = 3'b000;
        push(2, 0, 504, 520, 1023, k + 786, k + 786);
        wait_pops(3, 2000);
        ch_mode[2] = 1;
        load = 3'b100; init_gain = 10'd3;
        @(posedge clk); #1 load = 3'b000;
        push(0, 255, 496, 520, 3, k + 1048, k + 1048);
        push(1, 0, 496, 528, 3, k + 1310, k + 1310);
        push(2, 255, 496, 528, 0, k + 1572, k + 1572);
        wait_pops(6, 2000);
        stop_run("stop1");

        // In-band level holds the gain; an inverted band holds it whatever the level.
        ch_mode = '{2, 2, 0};
        start_run(k);
        push(0, 80, 496, 528, 0, k + 262, k + 262);
        wait_pops(7, 2000);
        target_lo = 8'd100; target_hi = 8'd50;
        push(1, 80, 496, 528, 0, k + 524, k + 524);
        push(2, 0, 496, 528, 0, k + 786, k + 786);
        wait_pops(9, 2000);
        stop_run("stop2");
        target_lo = 8'd64; target_hi = 8'd96;

        // Gapped qualifier: same hit count, window stretched to 511..512 cycles.
        se_mode = 1;
        start_run(k);
        push(0, 80, 496, 528, 0, k + 517, k + 518);
        push(1, 80, 496, 528, 0, k + 1034, k + 1036);
        wait_pops(10, 2000);
        c10 = last_upd_cyc;
        wait_pops(11, 2000);
        check_range("gapped_interval", last_upd_cyc - c10, 517, 518);
        stop_run("stop3");
        se_mode = 0;

        // Abort mid-window: no update, gains held, restart at ch1 with full window.
        ch_mode = '{1, 0, 0};
        start_run(k);
        repeat (105) @(posedge clk);
        #1;
        stop_run("abort");
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("abort_gain_ch1", gain_ch1, 496);
        check("abort_gain_ch2", gain_ch2, 528);
        check("abort_gain_ch3", gain_ch3, 0);
        check("abort_level", last_level, 80);
        check("abort_pops", n_pop, 11);

        start_run(k);
        push(0, 255, 300, 528, 0, k + 262, k + 262);
        repeat (261) @(posedge clk);
        #1;
        load = 3'b001; init_gain = 10'd300;
        @(posedge clk); #1 load = 3'b000;
        wait_pops(12, 2000);

        // Asynchronous reset in the middle of the ch2 window.
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_gain_ch1", gain_ch1, 512);
        check("arst_gain_ch2", gain_ch2, 512);
        check("arst_gain_ch3", gain_ch3, 512);
        check("arst_busy", busy, 0);
        check("arst_update", update, 0);
        check("arst_level", last_level, 0);
        check("arst_ch_sel", ch_sel, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("release_busy_before", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("release_busy_after", busy, 1);
        @(posedge clk);
        #1;
        stop_run("stop_end");
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
